// File: rtl/hazard_control_unit.sv
// Load-use hazard and taken-branch controller for the 5-stage MIPS pipeline.
// Drives PC/IF-ID write enables, ID/EX bubble mux and IF/ID flush, with saturating activity counters.
module hazard_control_unit #(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned LOAD_STALL   = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             UsesRs,
    input  logic             UsesRt,
    input  logic [REG_W-1:0] rtExecution,
    input  logic             MemReadExecution,
    input  logic             BranchTaken,
    input  logic             CounterClear,
    output logic             PCWrite,
    output logic             DecodeWrite,
    output logic             MuxControl,
    output logic             IFIDFlush,
    output logic             Stalling,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int unsigned REM_W = 3;
    localparam logic [REM_W-1:0] STALL_RELOAD = REM_W'(LOAD_STALL - 1);
    localparam logic [REM_W-1:0] FLUSH_RELOAD = REM_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] rem_nx;
    logic             hazard;
    logic             pc_write_c;
    logic             decode_write_c;
    logic             mux_control_c;
    logic             ifid_flush_c;
    logic             stall_inc;
    logic             flush_inc;

    // Out-of-range cycle counts cannot be represented by the 3-bit remaining counter.
    if (LOAD_STALL == 0 || LOAD_STALL > 7) begin : g_bad_load_stall
        $error("hazard_control_unit: LOAD_STALL=%0d outside 1..7", LOAD_STALL);
    end
    if (FLUSH_CYCLES == 0 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
        $error("hazard_control_unit: FLUSH_CYCLES=%0d outside 1..7", FLUSH_CYCLES);
    end

    // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign hazard = MemReadExecution && (rtExecution != '0) &&
                    ((UsesRs && (rs == rtExecution)) || (UsesRt && (rt == rtExecution)));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= RUN;
            rem   <= '0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
        end
    end

    // Next state and raw controls; a taken branch wins over any stall or flush in progress.
    always_comb begin
        state_nx       = state;
        rem_nx         = rem;
        pc_write_c     = 1'b1;
        decode_write_c = 1'b1;
        mux_control_c  = 1'b0;
        ifid_flush_c   = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        if (BranchTaken) begin
            ifid_flush_c  = 1'b1;
            mux_control_c = 1'b1;
            flush_inc     = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nx = FLUSH;
                rem_nx   = FLUSH_RELOAD;
            end else begin
                state_nx = RUN;
                rem_nx   = '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        pc_write_c     = 1'b0;
                        decode_write_c = 1'b0;
                        mux_control_c  = 1'b1;
                        stall_inc      = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_nx = STALL;
                            rem_nx   = STALL_RELOAD;
                        end
                    end
                end
                STALL: begin
                    pc_write_c     = 1'b0;
                    decode_write_c = 1'b0;
                    mux_control_c  = 1'b1;
                    stall_inc      = 1'b1;
                    if (rem <= REM_W'(1)) begin
                        state_nx = RUN;
                        rem_nx   = '0;
                    end else begin
                        rem_nx = rem - REM_W'(1);
                    end
                end
                FLUSH: begin
                    ifid_flush_c  = 1'b1;
                    mux_control_c = 1'b1;
                    if (rem <= REM_W'(1)) begin
                        state_nx = RUN;
                        rem_nx   = '0;
                    end else begin
                        rem_nx = rem - REM_W'(1);
                    end
                end
                default: begin
                    state_nx = RUN;
                    rem_nx   = '0;
                end
            endcase
        end
    end

    // Reset forces the free-flow controls regardless of what Decode presents.
    assign PCWrite     = !Reset || pc_write_c;
    assign DecodeWrite = !Reset || decode_write_c;
    assign MuxControl  = Reset && mux_control_c;
    assign IFIDFlush   = Reset && ifid_flush_c;
    assign Stalling    = Reset && ((state == STALL) || hazard);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else if (CounterClear) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (stall_inc && (StallCount != CNT_MAX)) StallCount <= StallCount + CNT_W'(1);
            if (flush_inc && (FlushCount != CNT_MAX)) FlushCount <= FlushCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Checks two differently parameterised hazard_control_unit instances against a
// cycle-budget model of pending stall/flush cycles, plus pinned directed expectations.
module tb_hazard_control_unit;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [4:0] rs = '0, rt = '0, rte = '0;
    logic       urs = 1'b0, urt = 1'b0, mr = 1'b0, br = 1'b0, clr = 1'b0;

    wire [1:0]  pcw, dw, mux, flo, stl;
    logic [3:0]  sc_a, fc_a;
    logic [15:0] sc_b, fc_b;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    hazard_control_unit #(.REG_W(5), .LOAD_STALL(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_a (
        .Clk(Clk), .Reset(Reset), .rs(rs), .rt(rt), .UsesRs(urs), .UsesRt(urt),
        .rtExecution(rte), .MemReadExecution(mr), .BranchTaken(br), .CounterClear(clr),
        .PCWrite(pcw[0]), .DecodeWrite(dw[0]), .MuxControl(mux[0]), .IFIDFlush(flo[0]),
        .Stalling(stl[0]), .StallCount(sc_a), .FlushCount(fc_a));

    hazard_control_unit #(.REG_W(5), .LOAD_STALL(1), .FLUSH_CYCLES(1), .CNT_W(16)) u_b (
        .Clk(Clk), .Reset(Reset), .rs(rs), .rt(rt), .UsesRs(urs), .UsesRt(urt),
        .rtExecution(rte), .MemReadExecution(mr), .BranchTaken(br), .CounterClear(clr),
        .PCWrite(pcw[1]), .DecodeWrite(dw[1]), .MuxControl(mux[1]), .IFIDFlush(flo[1]),
        .Stalling(stl[1]), .StallCount(sc_b), .FlushCount(fc_b));

    // Model: remaining stall/flush cycles still owed after the current one, and event counts.
    int ls_p[2]   = '{3, 1};
    int fc_p[2]   = '{2, 1};
    int cmax[2]   = '{15, 65535};
    int sl[2]     = '{0, 0};
    int fll[2]    = '{0, 0};
    int m_sc[2]   = '{0, 0};
    int m_fc[2]   = '{0, 0};

    typedef struct {
        bit pcw, dw, mux, fl, stl;
        int sl, fll, sc, fc;
    } mres_t;

    function automatic mres_t model_eval(int k);
        mres_t r;
        bit h, sinc, finc;
        h = mr && (rte != 0) && ((urs && rs == rte) || (urt && rt == rte));
        r.pcw = 1; r.dw = 1; r.mux = 0; r.fl = 0;
        r.stl = (sl[k] > 0) || h;
        r.sl = sl[k]; r.fll = fll[k];
        sinc = 0; finc = 0;
        if (br) begin
            r.fl = 1; r.mux = 1; r.fll = fc_p[k] - 1; r.sl = 0; finc = 1;
        end else if (fll[k] > 0) begin
            r.fl = 1; r.mux = 1; r.fll = fll[k] - 1;
        end else if (sl[k] > 0) begin
            r.pcw = 0; r.dw = 0; r.mux = 1; r.sl = sl[k] - 1; sinc = 1;
        end else if (h) begin
            r.pcw = 0; r.dw = 0; r.mux = 1; r.sl = ls_p[k] - 1; sinc = 1;
        end
        r.sc = clr ? 0 : ((sinc && m_sc[k] < cmax[k]) ? m_sc[k] + 1 : m_sc[k]);
        r.fc = clr ? 0 : ((finc && m_fc[k] < cmax[k]) ? m_fc[k] + 1 : m_fc[k]);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge Clk or negedge Reset) begin
        mres_t r;
        for (int k = 0; k < 2; k++) begin
            if (!Reset) begin
                sl[k] = 0; fll[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            end else begin
                r = model_eval(k);
                sl[k] = r.sl; fll[k] = r.fll; m_sc[k] = r.sc; m_fc[k] = r.fc;
            end
        end
    end

    always @(negedge Clk) begin
        mres_t r;
        string nm;
        for (int k = 0; k < 2; k++) begin
            nm = (k == 0) ? "a" : "b";
            if (!Reset) begin
                r.pcw = 1; r.dw = 1; r.mux = 0; r.fl = 0; r.stl = 0;
            end else begin
                r = model_eval(k);
            end
            chk({nm, ".PCWrite"},     int'(pcw[k]), int'(r.pcw));
            chk({nm, ".DecodeWrite"}, int'(dw[k]),  int'(r.dw));
            chk({nm, ".MuxControl"},  int'(mux[k]), int'(r.mux));
            chk({nm, ".IFIDFlush"},   int'(flo[k]), int'(r.fl));
            chk({nm, ".Stalling"},    int'(stl[k]), int'(r.stl));
            chk({nm, ".StallCount"},  (k == 0) ? int'(sc_a) : int'(sc_b), m_sc[k]);
            chk({nm, ".FlushCount"},  (k == 0) ? int'(fc_a) : int'(fc_b), m_fc[k]);
        end
    end

    task automatic step(input logic i_mr, input logic [4:0] i_rte, input logic [4:0] i_rs,
                        input logic [4:0] i_rt, input logic i_urs, input logic i_urt,
                        input logic i_br, input logic i_clr);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        mr = i_mr; rte = i_rte; rs = i_rs; rt = i_rt;
        urs = i_urs; urt = i_urt; br = i_br; clr = i_clr;
        @(negedge Clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        #1;
        chk("reset.a.PCWrite", int'(pcw[0]), 1);
        chk("reset.a.StallCount", int'(sc_a), 0);

        // lw $8 in EX, add reading $8 in Decode
        step(1, 8, 8, 0, 1, 0, 0, 0);
        chk("lu.a.PCWrite", int'(pcw[0]), 0);
        chk("lu.a.MuxControl", int'(mux[0]), 1);
        chk("lu.a.Stalling", int'(stl[0]), 1);
        chk("lu.b.PCWrite", int'(pcw[1]), 0);
        idle();
        chk("lu2.a.PCWrite", int'(pcw[0]), 0);
        chk("lu2.b.PCWrite", int'(pcw[1]), 1);
        chk("lu2.b.StallCount", int'(sc_b), 1);
        idle();
        chk("lu3.a.DecodeWrite", int'(dw[0]), 0);
        idle();
        chk("lu4.a.PCWrite", int'(pcw[0]), 1);
        chk("lu4.a.MuxControl", int'(mux[0]), 0);
        chk("lu4.a.StallCount", int'(sc_a), 3);

        // $0 destination and unused rs never hazard; rt match does
        step(1, 0, 0, 0, 1, 1, 0, 0);
        chk("zero.a.PCWrite", int'(pcw[0]), 1);
        chk("zero.a.Stalling", int'(stl[0]), 0);
        step(1, 8, 8, 0, 0, 0, 0, 0);
        chk("nors.a.PCWrite", int'(pcw[0]), 1);
        step(1, 9, 0, 9, 0, 1, 0, 0);
        chk("rt.a.PCWrite", int'(pcw[0]), 0);
        idle();
        idle();

        // taken branch, two flush cycles on a
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("br1.a.IFIDFlush", int'(flo[0]), 1);
        chk("br1.a.PCWrite", int'(pcw[0]), 1);
        idle();
        chk("br2.a.IFIDFlush", int'(flo[0]), 1);
        chk("br2.a.FlushCount", int'(fc_a), 1);
        chk("br2.b.IFIDFlush", int'(flo[1]), 0);
        idle();
        chk("br3.a.IFIDFlush", int'(flo[0]), 0);

        // branch in the second stall cycle aborts the stall
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 8, 8, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("bis.a.IFIDFlush", int'(flo[0]), 1);
        chk("bis.a.PCWrite", int'(pcw[0]), 1);
        idle();
        chk("bis.a.StallCount", int'(sc_a), 1);
        chk("bis.a.FlushCount", int'(fc_a), 1);
        chk("bis.a.IFIDFlush2", int'(flo[0]), 1);
        idle();

        // reset in the middle of the second stall cycle
        step(1, 8, 8, 0, 1, 0, 0, 0);
        step(1, 8, 8, 0, 1, 0, 0, 0);
        chk("rst.pre.a.PCWrite", int'(pcw[0]), 0);
        Reset = 1'b0;
        #1;
        chk("rst.a.PCWrite", int'(pcw[0]), 1);
        chk("rst.a.MuxControl", int'(mux[0]), 0);
        chk("rst.a.Stalling", int'(stl[0]), 0);
        chk("rst.a.StallCount", int'(sc_a), 0);
        idle();
        chk("rst.post.a.PCWrite", int'(pcw[0]), 1);
        chk("rst.post.a.StallCount", int'(sc_a), 0);

        // saturation on the 4-bit counter, then clear wins over increment
        repeat (25) step(1, 8, 8, 0, 1, 0, 0, 0);
        chk("sat.a.StallCount", int'(sc_a), 15);
        step(1, 8, 8, 0, 1, 0, 0, 1);
        step(1, 8, 8, 0, 1, 0, 0, 0);
        chk("clr.a.StallCount", int'(sc_a), 0);
        idle();
        idle();

        // randomized traffic with a small register range to provoke hazards
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0) Reset = 1'b0;
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
